// File: rtl/denise_sprite_serializer.sv
// rtl/denise_sprite_serializer.sv - Denise sprite channel: POS/CTL/DATA/DATB registers, start compare, 2-plane serialiser
// Optional feature macro: SPRITE_ONESHOT_EN (a load also disarms, so each DATA write displays once)
module denise_sprite_serializer (
  input  logic        clk,
  input  logic        reset,
  input  logic        clk7_en,
  input  logic        aen,
  input  logic [1:0]  address,
  input  logic [8:0]  hpos,
  input  logic [15:0] fmode,
  input  logic        shift,
  input  logic [47:0] chip48,
  input  logic [15:0] data_in,
  output logic [1:0]  sprdata,
  output logic        attach
);

  logic [8:0]  hstart;
  logic        armed;
  logic [63:0] data_hold;
  logic [63:0] datb_hold;
  logic [63:0] shifta;
  logic [63:0] shiftb;
  logic [63:0] fmt_word;
  logic        wr_pos;
  logic        wr_ctl;
  logic        wr_data;
  logic        wr_datb;
  logic        load;
  logic        unused_fmode;

  // Only the sprite width field of FMODE matters to this channel.
  assign unused_fmode = ^{fmode[15:4], fmode[1:0]};

  assign wr_pos  = aen && (address == 2'd0);
  assign wr_ctl  = aen && (address == 2'd1);
  assign wr_data = aen && (address == 2'd2);
  assign wr_datb = aen && (address == 2'd3);

  // A CTL write in the compare cycle disarms with priority, so it also blocks the load.
  assign load = armed && (hpos == hstart) && !wr_ctl;

  // Left-justify the written word together with the extra chip bits for wide sprites.
  always_comb begin
    fmt_word = {data_in, 48'h0};
    case (fmode[3:2])
      2'b00:   fmt_word = {data_in, 48'h0};
      2'b11:   fmt_word = {data_in, chip48};
      default: fmt_word = {data_in, chip48[47:32], 32'h0};
    endcase
  end

  // Register file and arm flag; the holding words are read by the load before being overwritten.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hstart    <= 9'd0;
      attach    <= 1'b0;
      armed     <= 1'b0;
      data_hold <= 64'h0;
      datb_hold <= 64'h0;
    end else if (clk7_en) begin
      if (wr_pos) begin
        hstart[8:1] <= data_in[7:0];
      end
      if (wr_ctl) begin
        hstart[0] <= data_in[0];
        attach    <= data_in[7];
      end
      if (wr_data) begin
        data_hold <= fmt_word;
      end
      if (wr_datb) begin
        datb_hold <= fmt_word;
      end
      if (wr_ctl) begin
        armed <= 1'b0;
      end else if (wr_data) begin
        armed <= 1'b1;
      end
`ifdef SPRITE_ONESHOT_EN
      else if (load) begin
        armed <= 1'b0;
      end
`endif
    end
  end

  // Shift registers: load on beam match, otherwise shift out MSB first with zero fill.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shifta <= 64'h0;
      shiftb <= 64'h0;
    end else if (clk7_en) begin
      if (load) begin
        shifta <= data_hold;
        shiftb <= datb_hold;
      end else if (shift) begin
        shifta <= {shifta[62:0], 1'b0};
        shiftb <= {shiftb[62:0], 1'b0};
      end
    end
  end

  assign sprdata = {shiftb[63], shifta[63]};

endmodule

// File: tb/tb_denise_sprite_serializer.sv
// tb/tb_denise_sprite_serializer.sv - self-checking bench for denise_sprite_serializer
module tb_denise_sprite_serializer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        clk7_en = 1'b0;
  logic        aen = 1'b0;
  logic [1:0]  address = 2'd0;
  logic [8:0]  hpos = 9'd0;
  logic [15:0] fmode = 16'h0;
  logic        shift = 1'b0;
  logic [47:0] chip48 = 48'h0;
  logic [15:0] data_in = 16'h0;
  logic [1:0]  sprdata;
  logic        attach;

  int checks = 0;
  int failures = 0;

  // reference model state
  logic [8:0]  m_hstart;
  logic        m_attach;
  logic        m_armed;
  logic [63:0] m_data;
  logic [63:0] m_datb;
  logic [1:0]  pix[$];
  logic [1:0]  obs[$];

  denise_sprite_serializer dut (
    .clk(clk), .reset(reset), .clk7_en(clk7_en), .aen(aen), .address(address),
    .hpos(hpos), .fmode(fmode), .shift(shift), .chip48(chip48), .data_in(data_in),
    .sprdata(sprdata), .attach(attach)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] fmt_model(input logic [15:0] fm, input logic [15:0] d, input logic [47:0] c);
    int bits;
    logic [63:0] full;
    logic [63:0] ones;
    bits = (fm[3:2] == 2'b00) ? 16 : (fm[3:2] == 2'b11) ? 64 : 32;
    full = {d, c};
    ones = '1;
    return (bits == 64) ? full : (full & ~(ones >> bits));
  endfunction

  function automatic logic [1:0] m_pix();
    return (pix.size() > 0) ? pix[0] : 2'b00;
  endfunction

  function automatic void model_reset();
    m_hstart = 0; m_attach = 0; m_armed = 0; m_data = 0; m_datb = 0;
    pix.delete();
  endfunction

  function automatic void model_step();
    bit wpos, wctl, wdata, wdatb, ld;
    logic [63:0] fw;
    wpos  = aen && address == 2'd0;
    wctl  = aen && address == 2'd1;
    wdata = aen && address == 2'd2;
    wdatb = aen && address == 2'd3;
    ld = m_armed && (hpos == m_hstart) && !wctl;
    fw = fmt_model(fmode, data_in, chip48);
    if (ld) begin
      pix.delete();
      for (int i = 0; i < 64; i++) pix.push_back({m_datb[63-i], m_data[63-i]});
    end else if (shift && pix.size() > 0) begin
      void'(pix.pop_front());
    end
    if (wpos) m_hstart[8:1] = data_in[7:0];
    if (wctl) begin m_hstart[0] = data_in[0]; m_attach = data_in[7]; m_armed = 0; end
    if (wdata) begin m_data = fw; m_armed = 1; end
    if (wdatb) m_datb = fw;
`ifdef SPRITE_ONESHOT_EN
    if (ld && !wdata) m_armed = 0;
`endif
  endfunction

  task automatic cyc(input bit en);
    clk7_en = en;
    @(posedge clk);
    if (en) model_step();
    #1;
  endtask

  task automatic wr(input logic [1:0] a, input logic [15:0] d);
    aen = 1'b1; address = a; data_in = d;
    cyc(1);
    aen = 1'b0;
  endtask

  // Beam sweep with clk7_en every 4th clock; optional register write at one hpos.
  task automatic sweep(input int from, input int to, input int wr_at, input logic [1:0] wa, input logic [15:0] wd);
    obs.delete();
    shift = 1'b1;
    for (int h = from; h <= to; h++) begin
      hpos = h[8:0];
      if (h == wr_at) begin aen = 1'b1; address = wa; data_in = wd; end
      cyc(1);
      aen = 1'b0;
      checks++;
      if (sprdata !== m_pix()) begin
        failures++;
        $display("FAIL sweep hpos=%0d sprdata=%b expected=%b", h, sprdata, m_pix());
      end
      obs.push_back(sprdata);
      repeat (3) cyc(0);
    end
  endtask

  task automatic test_reset();
    #2;
    checks++;
    if (sprdata !== 2'b00 || attach !== 1'b0) begin
      failures++;
      $display("FAIL reset_initial sprdata=%b attach=%b expected 00/0", sprdata, attach);
    end
    model_reset();
    @(negedge clk); reset = 1'b0;
    hpos = 0;
    wr(2'd1, 16'h0080);
    wr(2'd0, 16'h0002);
    wr(2'd2, 16'hFFFF);
    sweep(0, 8, -1, 2'd0, 16'h0);
    checks++;
    if (sprdata !== 2'b01 || attach !== 1'b1) begin
      failures++;
      $display("FAIL reset_precondition sprdata=%b attach=%b expected 01/1", sprdata, attach);
    end
    clk7_en = 1'b0;
    #2 reset = 1'b1;
    #1;
    checks++;
    if (sprdata !== 2'b00 || attach !== 1'b0) begin
      failures++;
      $display("FAIL reset_async sprdata=%b attach=%b expected 00/0", sprdata, attach);
    end
    model_reset();
    @(negedge clk); reset = 1'b0;
    sweep(0, 511, -1, 2'd0, 16'h0);
    foreach (obs[i]) begin
      checks++;
      if (obs[i] !== 2'b00) begin
        failures++;
        $display("FAIL reset_sweep hpos=%0d sprdata=%b expected=00", i, obs[i]);
      end
    end
  endtask

  task automatic test_16bit();
    fmode = 16'h0; hpos = 0;
    wr(2'd0, 16'h0040);
    wr(2'd1, 16'h0000);
    wr(2'd3, 16'hF0F0);
    wr(2'd2, 16'hAAAA);
    sweep(0, 'hD0, -1, 2'd0, 16'h0);
    checks++;
    if (obs['h7F] !== 2'b00 || obs['h80] !== 2'b11 || obs['h81] !== 2'b10 ||
        obs['h84] !== 2'b01 || obs['h85] !== 2'b00 || obs['h88] !== 2'b11 ||
        obs['h90] !== 2'b00 || obs['hC0] !== 2'b00) begin
      failures++;
      $display("FAIL pix16 got %b %b %b %b %b %b %b %b expected 00 11 10 01 00 11 00 00",
               obs['h7F], obs['h80], obs['h81], obs['h84], obs['h85], obs['h88], obs['h90], obs['hC0]);
    end
  endtask

  task automatic test_disarm();
    fmode = 16'h0; hpos = 0;
    wr(2'd0, 16'h0040);
    wr(2'd3, 16'hF0F0);
    wr(2'd2, 16'hAAAA);
    sweep(0, 'h70, -1, 2'd0, 16'h0);
    hpos = 9'h71;
    wr(2'd1, 16'h0080);
    sweep('h72, 'hD0, -1, 2'd0, 16'h0);
    sweep(0, 'hD0, -1, 2'd0, 16'h0);
    begin
      int nz = 0;
      foreach (obs[i]) if (obs[i] !== 2'b00) nz++;
      checks++;
      if (nz != 0 || attach !== 1'b1) begin
        failures++;
        $display("FAIL disarm nonzero_pixels=%0d attach=%b expected 0/1", nz, attach);
      end
    end
  endtask

  task automatic test_64bit();
    logic [63:0] abits, bbits;
    fmode = 16'h000C; hpos = 0; chip48 = 48'h0;
    wr(2'd3, 16'h0000);
    wr(2'd1, 16'h0000);
    wr(2'd0, 16'h0040);
    chip48 = 48'h123456789ABC;
    wr(2'd2, 16'hFFFF);
    chip48 = {16'($urandom), 32'($urandom)};
    sweep(0, 'hD0, -1, 2'd0, 16'h0);
    for (int i = 0; i < 64; i++) begin
      abits[63-i] = obs['h80+i][0];
      bbits[63-i] = obs['h80+i][1];
    end
    checks++;
    if (abits !== 64'hFFFF_1234_5678_9ABC || bbits !== 64'h0 || obs['hC0] !== 2'b00) begin
      failures++;
      $display("FAIL wide64 a=%h b=%h tail=%b expected ffff123456789abc/0/00", abits, bbits, obs['hC0]);
    end
  endtask

  task automatic test_collision();
    logic [15:0] a16;
    fmode = 16'h0; hpos = 0; chip48 = {16'($urandom), 32'($urandom)};
    wr(2'd1, 16'h0000);
    wr(2'd0, 16'h0040);
    wr(2'd3, 16'h0000);
    wr(2'd2, 16'hAAAA);
    sweep(0, 'hD0, 'h80, 2'd2, 16'h0001);
    for (int i = 0; i < 16; i++) a16[15-i] = obs['h80+i][0];
    checks++;
    if (a16 !== 16'hAAAA) begin
      failures++;
      $display("FAIL collision_old got=%h expected=aaaa", a16);
    end
    sweep(0, 'hD0, -1, 2'd0, 16'h0);
    for (int i = 0; i < 16; i++) a16[15-i] = obs['h80+i][0];
    checks++;
    if (a16 !== 16'h0001) begin
      failures++;
      $display("FAIL collision_next got=%h expected=0001", a16);
    end
    sweep(0, 'hD0, 'h80, 2'd1, 16'h0000);
    begin
      int nz = 0;
      foreach (obs[i]) if (i >= 'h81 && obs[i] !== 2'b00) nz++;
      checks++;
      if (nz != 0) begin
        failures++;
        $display("FAIL collision_ctl nonzero_pixels=%0d expected=0", nz);
      end
    end
  endtask

  task automatic test_repeat();
    logic [15:0] a16;
    fmode = 16'h0; hpos = 0;
    wr(2'd1, 16'h0000);
    wr(2'd2, 16'h5A3C);
    sweep(0, 'hD0, -1, 2'd0, 16'h0);
    for (int i = 0; i < 16; i++) a16[15-i] = obs['h80+i][0];
    checks++;
    if (a16 !== 16'h5A3C) begin
      failures++;
      $display("FAIL repeat_line1 got=%h expected=5a3c", a16);
    end
    sweep(0, 'hD0, -1, 2'd0, 16'h0);
    for (int i = 0; i < 16; i++) a16[15-i] = obs['h80+i][0];
    checks++;
`ifdef SPRITE_ONESHOT_EN
    if (a16 !== 16'h0000) begin
      failures++;
      $display("FAIL repeat_line2 got=%h expected=0000", a16);
    end
`else
    if (a16 !== 16'h5A3C) begin
      failures++;
      $display("FAIL repeat_line2 got=%h expected=5a3c", a16);
    end
`endif
  endtask

  task automatic test_random();
    bit en;
    for (int n = 0; n < 6000; n++) begin
      en = ($urandom_range(0, 1) == 1);
      aen = ($urandom_range(0, 15) == 0);
      address = 2'($urandom);
      data_in = 16'($urandom);
      if ($urandom_range(0, 63) == 0) fmode = 16'($urandom);
      chip48 = {16'($urandom), 32'($urandom)};
      shift = ($urandom_range(0, 3) != 0);
      cyc(en);
      aen = 1'b0;
      if (en) hpos = hpos + 9'd1;
      checks++;
      if (sprdata !== m_pix() || attach !== m_attach) begin
        failures++;
        $display("FAIL random n=%0d sprdata=%b attach=%b expected=%b/%b", n, sprdata, attach, m_pix(), m_attach);
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_16bit();
    test_disarm();
    test_64bit();
    test_collision();
    test_repeat();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
